// File: rtl/rnn_sequencer.sv
// +----------------------------------------------------------------------------+
// | rnn_sequencer                                                              |
// | Streams embedding vectors into the RNN accelerator, steps it per character |
// | and returns the dense-layer result. Optional macro: RNN_SEQ_TIMEOUT_EN.    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module rnn_sequencer #(
  parameter int EMB_LEN = 4,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  char_valid,
  output logic                  char_ready,
  input  logic [EMB_LEN*16-1:0] char_data,
  input  logic                  char_last,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [15:0]           res_data,
  output logic                  res_positive,
  output logic [CNT_W-1:0]      char_count,
  output logic                  busy,
  output logic                  timeout_err,
  output logic                  m_read,
  output logic                  m_write,
  output logic [2:0]            m_addr,
  output logic [31:0]           m_wdata,
  input  logic [31:0]           m_rdata
);

  localparam int c_IDX_W = ($clog2(EMB_LEN) > 8) ? $clog2(EMB_LEN) : 8;
  localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(EMB_LEN - 1);

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_LOAD_IN    = 4'd1,
    S_GO         = 4'd2,
    S_SETTLE1    = 4'd3,
    S_POLL_STEP  = 4'd4,
    S_FIN        = 4'd5,
    S_SETTLE2    = 4'd6,
    S_POLL_VALID = 4'd7,
    S_READ_RES   = 4'd8,
    S_DRAIN      = 4'd9,
`ifdef RNN_SEQ_TIMEOUT_EN
    S_HOLD       = 4'd10,
    S_ERROR      = 4'd11
`else
    S_HOLD       = 4'd10
`endif
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [EMB_LEN*16-1:0]   r_data;
  logic                    r_last;
  logic [c_IDX_W-1:0]      r_idx;
  logic [CNT_W-1:0]        r_count;
  logic [15:0]             r_res_data;
  logic                    r_res_pos;
  logic [15:0]             w_elem;

  assign w_elem       = r_data[{r_idx, 4'b0000} +: 16];
  assign busy         = (r_state != S_IDLE);
  assign char_count   = r_count;
  assign res_data     = r_res_data;
  assign res_positive = r_res_pos;

`ifdef RNN_SEQ_TIMEOUT_EN
  localparam int c_TO_W = $clog2(TIMEOUT + 1);
  localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT - 1);

  logic [c_TO_W-1:0] r_poll_cnt;
  logic              r_timeout;
  logic              w_poll_expired;

  assign w_poll_expired = (r_poll_cnt == c_TO_LAST);
  assign timeout_err    = r_timeout;
`else
  assign timeout_err = 1'b0;
`endif

  // Only bit 0 (status) and the low half-word (result) of read data matter.
  logic w_unused_rdata;
  assign w_unused_rdata = &{1'b0, m_rdata[31:16], (TIMEOUT > 0)};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    m_read     = 1'b0;
    m_write    = 1'b0;
    m_addr     = 3'd0;
    m_wdata    = 32'h0;
    char_ready = 1'b0;
    res_valid  = 1'b0;
    case (r_state)
      S_IDLE: begin
        char_ready = 1'b1;
        if (char_valid) w_next = S_LOAD_IN;
      end
      S_LOAD_IN: begin
        m_write = 1'b1;
        m_addr  = 3'd1;
        m_wdata = {8'h00, r_idx[7:0], w_elem};
        if (r_idx == c_LAST_IDX) w_next = S_GO;
      end
      S_GO: begin
        m_write = 1'b1;
        w_next  = S_SETTLE1;
      end
      S_SETTLE1: w_next = S_POLL_STEP;
      S_POLL_STEP: begin
        m_read = 1'b1;
        m_addr = 3'd1;
        if (m_rdata[0]) w_next = r_last ? S_FIN : S_IDLE;
`ifdef RNN_SEQ_TIMEOUT_EN
        else if (w_poll_expired) w_next = S_ERROR;
`endif
      end
      S_FIN: begin
        m_write = 1'b1;
        m_addr  = 3'd7;
        w_next  = S_SETTLE2;
      end
      S_SETTLE2: w_next = S_POLL_VALID;
      S_POLL_VALID: begin
        m_read = 1'b1;
        if (m_rdata[0]) w_next = S_READ_RES;
`ifdef RNN_SEQ_TIMEOUT_EN
        else if (w_poll_expired) w_next = S_ERROR;
`endif
      end
      S_READ_RES: begin
        m_read = 1'b1;
        m_addr = 3'd7;
        w_next = S_DRAIN;
      end
      S_DRAIN: w_next = S_HOLD;
      S_HOLD: begin
        res_valid = 1'b1;
        if (res_ready) w_next = S_IDLE;
      end
`ifdef RNN_SEQ_TIMEOUT_EN
      S_ERROR: w_next = S_ERROR;
`endif
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data     <= '0;
      r_last     <= 1'b0;
      r_idx      <= '0;
      r_count    <= '0;
      r_res_data <= 16'h0;
      r_res_pos  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (char_valid) begin
            r_data <= char_data;
            r_last <= char_last;
            r_idx  <= '0;
          end
        end
        S_LOAD_IN:   r_idx <= r_idx + 1'b1;
        S_POLL_STEP: if (m_rdata[0]) r_count <= r_count + 1'b1;
        S_READ_RES: begin
          r_res_data <= m_rdata[15:0];
          r_res_pos  <= ~m_rdata[15];
        end
        S_HOLD:      if (res_ready) r_count <= '0;
        default: ;
      endcase
    end
  end

`ifdef RNN_SEQ_TIMEOUT_EN
  // Counter is held at zero outside the poll states, so it restarts on every entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_poll_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      if (r_state == S_POLL_STEP || r_state == S_POLL_VALID) begin
        r_poll_cnt <= r_poll_cnt + 1'b1;
      end else begin
        r_poll_cnt <= '0;
      end
      if (w_next == S_ERROR && r_state != S_ERROR) r_timeout <= 1'b1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_rnn_sequencer.sv
// +----------------------------------------------------------------------------+
// | tb_rnn_sequencer                                                           |
// | Self-checking bench with a behavioural accelerator model and bus monitor.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_rnn_sequencer;

  localparam int EMB_LEN = 4;
  localparam int CNT_W   = 16;
`ifdef RNN_SEQ_TIMEOUT_EN
  localparam int TIMEOUT = 16;
`else
  localparam int TIMEOUT = 1024;
`endif

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  char_valid;
  logic                  char_ready;
  logic [EMB_LEN*16-1:0] char_data;
  logic                  char_last;
  logic                  res_valid;
  logic                  res_ready;
  logic [15:0]           res_data;
  logic                  res_positive;
  logic [CNT_W-1:0]      char_count;
  logic                  busy;
  logic                  timeout_err;
  logic                  m_read;
  logic                  m_write;
  logic [2:0]            m_addr;
  logic [31:0]           m_wdata;
  logic [31:0]           m_rdata;

  rnn_sequencer #(.EMB_LEN(EMB_LEN), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .char_valid(char_valid), .char_ready(char_ready), .char_data(char_data), .char_last(char_last),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_positive(res_positive),
    .char_count(char_count), .busy(busy), .timeout_err(timeout_err),
    .m_read(m_read), .m_write(m_write), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Accelerator model: step completes step_delay cycles after the start write,
  // dense result becomes valid dense_delay cycles after the dense write.
  int          step_delay  = 0;
  int          dense_delay = 0;
  bit          never_ready = 1'b0;
  logic [15:0] acc_result  = 16'h0;
  logic [7:0]  step_left, dense_left;
  logic        step_armed, dense_armed;
  logic        step_done, dense_valid;

  assign step_done   = step_armed  && (step_left  == 8'd0) && !never_ready;
  assign dense_valid = dense_armed && (dense_left == 8'd0) && !never_ready;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_left <= 8'd0; dense_left <= 8'd0; step_armed <= 1'b0; dense_armed <= 1'b0;
    end else begin
      if (m_write && m_addr == 3'd0) begin
        step_left <= 8'(step_delay); step_armed <= 1'b1;
      end else if (step_left != 8'd0) begin
        step_left <= step_left - 8'd1;
      end
      if (m_write && m_addr == 3'd7) begin
        dense_left <= 8'(dense_delay); dense_armed <= 1'b1;
      end else if (dense_left != 8'd0) begin
        dense_left <= dense_left - 8'd1;
      end
      if (m_read && m_addr == 3'd7) dense_armed <= 1'b0;
    end
  end

  always_comb begin
    m_rdata = 32'h0;
    if (m_read) begin
      case (m_addr)
        3'd0:    m_rdata = {16'hCAFE, 15'h0, dense_valid};
        3'd1:    m_rdata = {16'hBEEF, 15'h0, step_done};
        3'd7:    m_rdata = {16'hA5A5, acc_result};
        default: m_rdata = 32'h0;
      endcase
    end
  end

  // Bus monitor: protocol rules every cycle, transaction log for the directed checks.
  logic [34:0] wr_q[$];
  logic [2:0]  rd_q[$];
  bit          need_idle = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      check("rd_wr_exclusive", 32'(m_read & m_write), 32'd0);
      if (need_idle) check("idle_after_cmd", 32'(m_read | m_write), 32'd0);
      need_idle = (m_write && (m_addr == 3'd0 || m_addr == 3'd7)) || (m_read && m_addr == 3'd7);
      if (m_write) wr_q.push_back({m_addr, m_wdata});
      if (m_read)  rd_q.push_back(m_addr);
    end else begin
      need_idle = 1'b0;
    end
  end

  logic [15:0] exp_count = 16'd0;

  task automatic check_reset_values(input string tag);
    check({tag, "_m_read"},  32'(m_read), 0);
    check({tag, "_m_write"}, 32'(m_write), 0);
    check({tag, "_m_addr"},  32'(m_addr), 0);
    check({tag, "_m_wdata"}, m_wdata, 0);
    check({tag, "_res_valid"}, 32'(res_valid), 0);
    check({tag, "_res_data"}, 32'(res_data), 0);
    check({tag, "_res_pos"}, 32'(res_positive), 0);
    check({tag, "_count"}, 32'(char_count), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_char_ready"}, 32'(char_ready), 1);
    check({tag, "_timeout"}, 32'(timeout_err), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_count = 16'd0;
    wr_q.delete();
    rd_q.delete();
  endtask

  task automatic send_char(input logic [EMB_LEN*16-1:0] d, input logic last);
    int n = 0;
    @(negedge clk);
    while (!char_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("char_ready_wait", 32'(char_ready), 1);
    char_valid = 1'b1;
    char_data  = d;
    char_last  = last;
    @(posedge clk);
    #1 char_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 500);
    check("idle_wait", 32'(busy), 0);
  endtask

  task automatic wait_res();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!res_valid && n < 500);
    check("res_wait", 32'(res_valid), 1);
  endtask

  task automatic check_char_writes(input logic [EMB_LEN*16-1:0] d);
    logic [34:0] e;
    for (int i = 0; i < EMB_LEN; i++) begin
      if (wr_q.size() == 0) begin
        check("ld_missing", 32'(wr_q.size()), 1);
        return;
      end
      e = wr_q.pop_front();
      check("ld_addr", 32'(e[34:32]), 32'd1);
      check("ld_data", e[31:0], {8'h00, 8'(i), d[16*i +: 16]});
    end
    if (wr_q.size() == 0) begin
      check("go_missing", 32'(wr_q.size()), 1);
      return;
    end
    e = wr_q.pop_front();
    check("go_addr", 32'(e[34:32]), 32'd0);
    check("go_data", e[31:0], 32'd0);
  endtask

  task automatic run_seq(input int len, input logic [15:0] result, input int hold);
    logic [EMB_LEN*16-1:0] d;
    logic [34:0]           e;
    int                    n7;
    wr_q.delete();
    rd_q.delete();
    acc_result  = result;
    dense_delay = $urandom_range(0, 8);
    for (int c = 0; c < len; c++) begin
      d = {$urandom(), $urandom()};
      step_delay = $urandom_range(0, 6);
      send_char(d, c == len - 1);
      if (c != len - 1) begin
        wait_idle();
        exp_count = exp_count + 16'd1;
        check("seq_count", 32'(char_count), 32'(exp_count));
      end else begin
        wait_res();
      end
      check_char_writes(d);
    end
    exp_count = exp_count + 16'd1;
    check("fin_nwrites", 32'(wr_q.size()), 1);
    if (wr_q.size() != 0) begin
      e = wr_q.pop_front();
      check("fin_addr", 32'(e[34:32]), 32'd7);
      check("fin_data", e[31:0], 32'd0);
    end
    n7 = 0;
    foreach (rd_q[i]) if (rd_q[i] == 3'd7) n7++;
    check("res_reads", 32'(n7), 1);
    check("res_data", 32'(res_data), 32'(result));
    check("res_positive", 32'(res_positive), 32'($signed(result) >= 0));
    check("res_count", 32'(char_count), 32'(exp_count));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_valid", 32'(res_valid), 1);
      check("hold_data", 32'(res_data), 32'(result));
    end
    res_ready = 1'b1;
    @(posedge clk);
    #1 res_ready = 1'b0;
    exp_count = 16'd0;
    check("rel_busy", 32'(busy), 0);
    check("rel_valid", 32'(res_valid), 0);
    check("rel_count", 32'(char_count), 0);
    check("rel_ready", 32'(char_ready), 1);
  endtask

  initial begin
    logic [EMB_LEN*16-1:0] d1;
    logic [31:0]           exp1[4];
    logic [34:0]           e;
    int                    n;

    rst_n = 1'b0; char_valid = 1'b0; char_data = '0; char_last = 1'b0; res_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("rst_in");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_values("rst_out");

    // Single non-last character with known elements.
    d1   = {16'h0400, 16'h0300, 16'h0200, 16'h0100};
    exp1 = '{32'h00000100, 32'h00010200, 32'h00020300, 32'h00030400};
    step_delay = 3;
    wr_q.delete(); rd_q.delete();
    send_char(d1, 1'b0);
    wait_idle();
    exp_count = exp_count + 16'd1;
    check("t1_nwrites", 32'(wr_q.size()), 5);
    for (int i = 0; i < 4 && wr_q.size() != 0; i++) begin
      e = wr_q.pop_front();
      check("t1_addr", 32'(e[34:32]), 1);
      check("t1_data", e[31:0], exp1[i]);
    end
    if (wr_q.size() != 0) begin
      e = wr_q.pop_front();
      check("t1_go", 32'(e), 32'd0);
    end
    check("t1_nreads", 32'(rd_q.size()), 3);
    foreach (rd_q[i]) check("t1_rd_addr", 32'(rd_q[i]), 1);
    check("t1_count", 32'(char_count), 1);
    check("t1_ready", 32'(char_ready), 1);

    // Reset while polling a step that never completes.
    never_ready = 1'b1;
    send_char({$urandom(), $urandom()}, 1'b0);
    n = 0;
    while (!(m_read && m_addr == 3'd1) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("poll_reached", 32'(m_read && m_addr == 3'd1), 1);
    #2 rst_n = 1'b0;
    #1 check_reset_values("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    never_ready = 1'b0;
    exp_count = 16'd0;
    wr_q.delete(); rd_q.delete();
    d1 = {$urandom(), $urandom()};
    step_delay = 1;
    send_char(d1, 1'b0);
    wait_idle();
    check_char_writes(d1);
    check("post_rst_count", 32'(char_count), 1);

    // Three characters ending in a negative result.
    do_reset();
    run_seq(3, 16'hFF80, 1);
    // Positive result held back for 10 cycles.
    run_seq(1, 16'h0040, 10);
    for (int s = 0; s < 6; s++) begin
      run_seq($urandom_range(1, 4), 16'($urandom()), $urandom_range(0, 3));
    end

`ifdef RNN_SEQ_TIMEOUT_EN
    do_reset();
    never_ready = 1'b1;
    send_char({$urandom(), $urandom()}, 1'b0);
    n = 0;
    while (!timeout_err && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("to_flag", 32'(timeout_err), 1);
    check("to_polls", 32'(rd_q.size()), TIMEOUT);
    char_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("err_ready", 32'(char_ready), 0);
      check("err_busy", 32'(busy), 1);
      check("err_bus", 32'(m_read | m_write), 0);
      check("err_sticky", 32'(timeout_err), 1);
    end
    char_valid = 1'b0;
    never_ready = 1'b0;
    do_reset();
    @(negedge clk);
    check("to_cleared", 32'(timeout_err), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
